riscv_rf_wb_arbiter: RTL and testbench

Write-side initiator for the 64-bit, 32-entry integer register file. Merges single-cycle pipeline writeback with results from a long-latency unit (mul/div) into the register file's single write port. Long-latency results are buffered in a small FIFO and drained into free write slots. A per-register busy scoreboard lets decode stall on pending long-latency destinations.

---
 rtl/riscv_rf_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_riscv_rf_wb_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_rf_wb_arbiter.sv
// riscv_rf_wb_arbiter
//
// Write-side initiator for the 64-bit x 32 integer register file. Merges the
// single-cycle pipeline writeback with long-latency (mul/div) results into the
// register file's single write port. Long-latency results wait in a small FIFO
// and drain into free write slots. A FIFO that has been blocked for STARVE_MAX
// consecutive cycles takes the slot from the pipeline. A per-register busy
// scoreboard lets decode stall on pending long-latency destinations.
//
// Optional feature macro: RISCV_WBARB_FWD_EN adds rsN forwarding outputs that
// expose this cycle's write to decode and mask the matching busy bit.
//
// Ports:
//   i_riscv_wbarb_clk             clock, rising edge
//   i_riscv_rf_rst                asynchronous active-high reset
//   i_riscv_wbarb_pipe_*          pipeline writeback (regwrite, rdaddr, rddata)
//   o_riscv_wbarb_pipe_stall      pipeline write not taken; pipe holds it
//   i/o_riscv_wbarb_ll_*          long-latency result handshake (valid/ready)
//   i_riscv_wbarb_issue_*         long-latency issue, sets busy[rd]
//   i_riscv_wbarb_rs1/2addr       decode sources
//   o_riscv_wbarb_rs1/2_busy      source has a pending long-latency write
//   o_riscv_wbarb_rs1/2_fwd_*     (RISCV_WBARB_FWD_EN) same-cycle write bypass
//   o_riscv_rf_*                  register file write port (combinational)

module riscv_rf_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        i_riscv_wbarb_clk,
    input  logic        i_riscv_rf_rst,
    input  logic        i_riscv_wbarb_pipe_regwrite,
    input  logic [4:0]  i_riscv_wbarb_pipe_rdaddr,
    input  logic [63:0] i_riscv_wbarb_pipe_rddata,
    output logic        o_riscv_wbarb_pipe_stall,
    input  logic        i_riscv_wbarb_ll_valid,
    output logic        o_riscv_wbarb_ll_ready,
    input  logic [4:0]  i_riscv_wbarb_ll_rdaddr,
    input  logic [63:0] i_riscv_wbarb_ll_rddata,
    input  logic        i_riscv_wbarb_issue_valid,
    input  logic [4:0]  i_riscv_wbarb_issue_rdaddr,
    input  logic [4:0]  i_riscv_wbarb_rs1addr,
    input  logic [4:0]  i_riscv_wbarb_rs2addr,
    output logic        o_riscv_wbarb_rs1_busy,
    output logic        o_riscv_wbarb_rs2_busy,
`ifdef RISCV_WBARB_FWD_EN
    output logic        o_riscv_wbarb_rs1_fwd_valid,
    output logic [63:0] o_riscv_wbarb_rs1_fwd_data,
    output logic        o_riscv_wbarb_rs2_fwd_valid,
    output logic [63:0] o_riscv_wbarb_rs2_fwd_data,
`endif
    output logic        o_riscv_rf_regwrite,
    output logic [4:0]  o_riscv_rf_rdaddr,
    output logic [63:0] o_riscv_rf_rddata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] StarveMax = CW'(STARVE_MAX);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [4:0]     fifo_rd_q   [DEPTH];
    logic [63:0]    fifo_data_q [DEPTH];
    logic [CW-1:0]  starve_q, starve_d;
    logic [31:0]    busy_q, busy_d;

    logic           fifo_empty, fifo_full;
    logic [4:0]     head_rd;
    logic [63:0]    head_data;
    logic           pipe_wr, starved, pop, push, ll_ready;
    logic           rf_we;
    logic [4:0]     rf_addr;
    logic [63:0]    rf_data;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_rd    = fifo_rd_q[rd_ptr_q[AW-1:0]];
    assign head_data  = fifo_data_q[rd_ptr_q[AW-1:0]];

    // x0 pipe writes are discarded and leave the slot free.
    assign pipe_wr  = i_riscv_wbarb_pipe_regwrite && (i_riscv_wbarb_pipe_rdaddr != 5'd0);
    assign starved  = !fifo_empty && (starve_q == StarveMax);
    assign pop      = !fifo_empty && (starved || !pipe_wr);
    // Full comes from registered pointers, so a pop does not reopen ready in
    // the same cycle.
    assign ll_ready = !fifo_full && !i_riscv_rf_rst;
    // rd==0 results complete the handshake but are not stored.
    assign push     = i_riscv_wbarb_ll_valid && ll_ready && (i_riscv_wbarb_ll_rdaddr != 5'd0);

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 64'd0;
        if (!i_riscv_rf_rst) begin
            if (pop) begin
                rf_we   = 1'b1;
                rf_addr = head_rd;
                rf_data = head_data;
            end else if (pipe_wr) begin
                rf_we   = 1'b1;
                rf_addr = i_riscv_wbarb_pipe_rdaddr;
                rf_data = i_riscv_wbarb_pipe_rddata;
            end
        end
    end

    // A pop with a live pipe write only happens when the FIFO is starved.
    assign o_riscv_wbarb_pipe_stall = !i_riscv_rf_rst && pipe_wr && starved;
    assign o_riscv_wbarb_ll_ready   = ll_ready;
    assign o_riscv_rf_regwrite      = rf_we;
    assign o_riscv_rf_rdaddr        = rf_addr;
    assign o_riscv_rf_rddata        = rf_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);

        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
        end

        // Clear before set so a same-cycle issue to the draining rd wins.
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (i_riscv_wbarb_issue_valid && (i_riscv_wbarb_issue_rdaddr != 5'd0)) begin
            busy_d[i_riscv_wbarb_issue_rdaddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_riscv_wbarb_clk or posedge i_riscv_rf_rst) begin
        if (i_riscv_rf_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge i_riscv_wbarb_clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q[AW-1:0]]   <= i_riscv_wbarb_ll_rdaddr;
            fifo_data_q[wr_ptr_q[AW-1:0]] <= i_riscv_wbarb_ll_rddata;
        end
    end

`ifdef RISCV_WBARB_FWD_EN
    logic fwd1, fwd2;

    assign fwd1 = rf_we && (rf_addr == i_riscv_wbarb_rs1addr) && (i_riscv_wbarb_rs1addr != 5'd0);
    assign fwd2 = rf_we && (rf_addr == i_riscv_wbarb_rs2addr) && (i_riscv_wbarb_rs2addr != 5'd0);

    assign o_riscv_wbarb_rs1_fwd_valid = fwd1;
    assign o_riscv_wbarb_rs1_fwd_data  = rf_data;
    assign o_riscv_wbarb_rs2_fwd_valid = fwd2;
    assign o_riscv_wbarb_rs2_fwd_data  = rf_data;
    // The value is available this cycle, so decode need not wait on it.
    assign o_riscv_wbarb_rs1_busy = busy_q[i_riscv_wbarb_rs1addr] && !fwd1;
    assign o_riscv_wbarb_rs2_busy = busy_q[i_riscv_wbarb_rs2addr] && !fwd2;
`else
    assign o_riscv_wbarb_rs1_busy = busy_q[i_riscv_wbarb_rs1addr];
    assign o_riscv_wbarb_rs2_busy = busy_q[i_riscv_wbarb_rs2addr];
`endif

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Self-checking bench for riscv_rf_wb_arbiter: directed scenarios with
// constant expectations plus a randomized run against a queue-based model.
module tb_riscv_rf_wb_arbiter;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_rw;
    logic [4:0]  pipe_rd;
    logic [63:0] pipe_data;
    logic        stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [63:0] ll_data;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_data;
`ifdef RISCV_WBARB_FWD_EN
    logic        f1v, f2v;
    logic [63:0] f1d, f2d;
`endif

    int checks   = 0;
    int failures = 0;

    riscv_rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .i_riscv_wbarb_clk           (clk),
        .i_riscv_rf_rst              (rst),
        .i_riscv_wbarb_pipe_regwrite (pipe_rw),
        .i_riscv_wbarb_pipe_rdaddr   (pipe_rd),
        .i_riscv_wbarb_pipe_rddata   (pipe_data),
        .o_riscv_wbarb_pipe_stall    (stall),
        .i_riscv_wbarb_ll_valid      (ll_valid),
        .o_riscv_wbarb_ll_ready      (ll_ready),
        .i_riscv_wbarb_ll_rdaddr     (ll_rd),
        .i_riscv_wbarb_ll_rddata     (ll_data),
        .i_riscv_wbarb_issue_valid   (iss_v),
        .i_riscv_wbarb_issue_rdaddr  (iss_rd),
        .i_riscv_wbarb_rs1addr       (rs1),
        .i_riscv_wbarb_rs2addr       (rs2),
        .o_riscv_wbarb_rs1_busy      (rs1_busy),
        .o_riscv_wbarb_rs2_busy      (rs2_busy),
`ifdef RISCV_WBARB_FWD_EN
        .o_riscv_wbarb_rs1_fwd_valid (f1v),
        .o_riscv_wbarb_rs1_fwd_data  (f1d),
        .o_riscv_wbarb_rs2_fwd_valid (f2v),
        .o_riscv_wbarb_rs2_fwd_data  (f2d),
`endif
        .o_riscv_rf_regwrite         (rf_we),
        .o_riscv_rf_rdaddr           (rf_rd),
        .o_riscv_rf_rddata           (rf_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_cnt;
    bit          m_busy[32];

    logic        e_we, e_stall, e_ready, e_b1, e_b2, e_pop;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic        e_f1v, e_f2v;

    task automatic model_clear;
        mq.delete();
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic model_eval;
        bit pw, ne, st;
        e_we = 0; e_rd = 0; e_data = 0; e_stall = 0; e_pop = 0;
        e_ready = 0; e_b1 = 0; e_b2 = 0; e_f1v = 0; e_f2v = 0;
        if (!rst) begin
            pw = pipe_rw && (pipe_rd != 0);
            ne = mq.size() != 0;
            st = ne && (m_cnt == STARVE_MAX);
            e_ready = mq.size() < DEPTH;
            if (ne && (st || !pw)) begin
                e_pop = 1; e_we = 1; e_rd = mq[0].rd; e_data = mq[0].data; e_stall = pw;
            end else if (pw) begin
                e_we = 1; e_rd = pipe_rd; e_data = pipe_data;
            end
            e_b1 = m_busy[rs1];
            e_b2 = m_busy[rs2];
`ifdef RISCV_WBARB_FWD_EN
            e_f1v = e_we && (e_rd == rs1) && (rs1 != 0);
            e_f2v = e_we && (e_rd == rs2) && (rs2 != 0);
            if (e_f1v) e_b1 = 0;
            if (e_f2v) e_b2 = 0;
`endif
        end
    endtask

    task automatic model_commit;
        bit   was_ne;
        ent_t t;
        if (rst) begin
            model_clear();
        end else begin
            was_ne = mq.size() != 0;
            if (e_pop) begin
                t = mq.pop_front();
                m_busy[t.rd] = 1'b0;
            end
            if (ll_valid && e_ready && (ll_rd != 0)) begin
                t.rd = ll_rd; t.data = ll_data;
                mq.push_back(t);
            end
            if (iss_v && (iss_rd != 0)) m_busy[iss_rd] = 1'b1;
            if (!was_ne || e_pop) m_cnt = 0;
            else if (m_cnt < STARVE_MAX) m_cnt++;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs;
        pipe_rw = 0; pipe_rd = 0; pipe_data = 0;
        ll_valid = 0; ll_rd = 0; ll_data = 0;
        iss_v = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic settle;
        #1;
        model_eval();
    endtask

    task automatic advance;
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        idle_inputs();
        rst = 1;
        model_clear();
        @(negedge clk);
        rst = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1;
        idle_inputs();
        pipe_rw = 1; pipe_rd = 5'd2; pipe_data = 64'h22;
        ll_valid = 1; ll_rd = 5'd5;
        #3;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%b exp=0", rf_we); end
        checks++; if (ll_ready !== 1'b0) begin failures++; $display("FAIL rst_ll_ready got=%b exp=0", ll_ready); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
        @(negedge clk);
        rst = 0;
        model_clear();
        // Pipe keeps the slot so both results stay queued.
        pipe_rw = 1; pipe_rd = 5'd1; pipe_data = 64'h11;
        ll_valid = 1; ll_rd = 5'd5; ll_data = 64'h55; iss_v = 1; iss_rd = 5'd5;
        settle(); advance();
        ll_rd = 5'd6; ll_data = 64'h66; iss_rd = 5'd6;
        settle(); advance();
        ll_valid = 0; iss_v = 0; rs1 = 5'd5; rs2 = 5'd6;
        settle();
        checks++; if ({rs1_busy, rs2_busy} !== 2'b11) begin failures++; $display("FAIL pre_rst_busy got=%b exp=11", {rs1_busy, rs2_busy}); end
        #2 rst = 1;
        #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL midrst_regwrite got=%b exp=0", rf_we); end
        checks++; if (ll_ready !== 1'b0) begin failures++; $display("FAIL midrst_ll_ready got=%b exp=0", ll_ready); end
        checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin failures++; $display("FAIL midrst_busy got=%b exp=00", {rs1_busy, rs2_busy}); end
        model_clear();
        @(negedge clk);
        rst = 0;
        pipe_rw = 0;
        settle();
        checks++; if (ll_ready !== 1'b1) begin failures++; $display("FAIL postrst_ll_ready got=%b exp=1", ll_ready); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL postrst_fifo_empty got=%b exp=0", rf_we); end
        checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin failures++; $display("FAIL postrst_busy got=%b exp=00", {rs1_busy, rs2_busy}); end
    endtask

    task automatic test_idle_drain;
        logic exp_b;
        do_reset();
        iss_v = 1; iss_rd = 5'd7; ll_valid = 1; ll_rd = 5'd7; ll_data = 64'hDEAD;
        settle(); advance();
        idle_inputs(); rs1 = 5'd7;
        settle();
`ifdef RISCV_WBARB_FWD_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL drain_regwrite got=%b exp=1", rf_we); end
        checks++; if (rf_rd !== 5'd7) begin failures++; $display("FAIL drain_rdaddr got=%0d exp=7", rf_rd); end
        checks++; if (rf_data !== 64'hDEAD) begin failures++; $display("FAIL drain_data got=%h exp=dead", rf_data); end
        checks++; if (rs1_busy !== exp_b) begin failures++; $display("FAIL drain_busy7 got=%b exp=%b", rs1_busy, exp_b); end
        advance();
        settle();
        checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL after_drain_busy7 got=%b exp=0", rs1_busy); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL after_drain_regwrite got=%b exp=0", rf_we); end
    endtask

    task automatic test_starvation;
        logic [4:0]  exp_rd;
        logic [63:0] exp_d;
        do_reset();
        pipe_rw = 1; pipe_rd = 5'd1; pipe_data = 64'd100;
        ll_valid = 1; ll_rd = 5'd3; ll_data = 64'h333; iss_v = 1; iss_rd = 5'd3;
        settle(); advance();
        ll_valid = 0; iss_v = 0;
        for (int k = 1; k <= 10; k++) begin
            pipe_data = 64'(100 + k);
            settle();
            exp_rd = (k == 9) ? 5'd3 : 5'd1;
            exp_d  = (k == 9) ? 64'h333 : 64'(100 + k);
            checks++; if (rf_rd !== exp_rd) begin failures++; $display("FAIL starve_rdaddr k=%0d got=%0d exp=%0d", k, rf_rd, exp_rd); end
            checks++; if (rf_data !== exp_d) begin failures++; $display("FAIL starve_data k=%0d got=%h exp=%h", k, rf_data, exp_d); end
            checks++; if (stall !== (k == 9)) begin failures++; $display("FAIL starve_stall k=%0d got=%b exp=%b", k, stall, k == 9); end
            advance();
        end
    endtask

    task automatic test_full;
        int stall_j = -1;
        int ready_j = -1;
        int got = 0;
        do_reset();
        pipe_rw = 1; pipe_rd = 5'd2; pipe_data = 64'h2;
        for (int i = 0; i < 4; i++) begin
            ll_valid = 1; ll_rd = 5'(10 + i); ll_data = 64'(32'h1000 + i);
            settle();
            checks++; if (ll_ready !== 1'b1) begin failures++; $display("FAIL full_push%0d_ready got=%b exp=1", i, ll_ready); end
            advance();
        end
        ll_rd = 5'd14; ll_data = 64'h1004;
        settle();
        checks++; if (ll_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ll_ready); end
        for (int j = 0; j < 20; j++) begin
            settle();
            if (stall === 1'b1 && stall_j < 0) stall_j = j;
            if (ll_ready === 1'b1) begin
                ready_j = j;
                advance();
                break;
            end
            advance();
        end
        checks++; if (stall_j !== 5) begin failures++; $display("FAIL full_pop_cycle got=%0d exp=5", stall_j); end
        checks++; if (ready_j !== 6) begin failures++; $display("FAIL full_accept_cycle got=%0d exp=6", ready_j); end
        idle_inputs();
        for (int j = 0; j < 10 && got < 4; j++) begin
            settle();
            if (rf_we === 1'b1) begin
                checks++;
                if (rf_rd !== 5'(11 + got) || rf_data !== 64'(32'h1001 + got)) begin
                    failures++;
                    $display("FAIL full_order n=%0d got=%0d/%h exp=%0d/%h", got, rf_rd, rf_data, 11 + got, 32'h1001 + got);
                end
                got++;
            end
            advance();
        end
        checks++; if (got !== 4) begin failures++; $display("FAIL full_drain_count got=%0d exp=4", got); end
    endtask

    task automatic test_x0;
        do_reset();
        pipe_rw = 1; pipe_rd = 5'd1; pipe_data = 64'h1;
        ll_valid = 1; ll_rd = 5'd4; ll_data = 64'h44; iss_v = 1; iss_rd = 5'd4;
        settle(); advance();
        ll_valid = 0; iss_v = 0;
        pipe_rd = 5'd0; pipe_data = 64'hBAD;
        settle();
        checks++; if ({rf_we, rf_rd} !== {1'b1, 5'd4}) begin failures++; $display("FAIL x0_pipe_drain got=%b/%0d exp=1/4", rf_we, rf_rd); end
        checks++; if (rf_data !== 64'h44) begin failures++; $display("FAIL x0_pipe_data got=%h exp=44", rf_data); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_pipe_stall got=%b exp=0", stall); end
        advance();
        idle_inputs();
        ll_valid = 1; ll_rd = 5'd0; ll_data = 64'h99; rs1 = 5'd4;
        settle();
        checks++; if (ll_ready !== 1'b1) begin failures++; $display("FAIL x0_ll_ready got=%b exp=1", ll_ready); end
        checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL x0_busy4 got=%b exp=0", rs1_busy); end
        advance();
        idle_inputs();
        settle();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL x0_ll_not_written got=%b exp=0", rf_we); end
    endtask

`ifdef RISCV_WBARB_FWD_EN
    task automatic test_fwd;
        do_reset();
        ll_valid = 1; ll_rd = 5'd9; ll_data = 64'h55; iss_v = 1; iss_rd = 5'd9;
        settle(); advance();
        idle_inputs(); rs1 = 5'd9; rs2 = 5'd8;
        settle();
        checks++; if (f1v !== 1'b1) begin failures++; $display("FAIL fwd1_valid got=%b exp=1", f1v); end
        checks++; if (f1d !== 64'h55) begin failures++; $display("FAIL fwd1_data got=%h exp=55", f1d); end
        checks++; if (rs1_busy !== 1'b0) begin failures++; $display("FAIL fwd1_busy got=%b exp=0", rs1_busy); end
        checks++; if (f2v !== 1'b0) begin failures++; $display("FAIL fwd2_valid got=%b exp=0", f2v); end
    endtask
`endif

    task automatic test_random;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pipe_rw   = ($urandom_range(0, 3) != 0);
            pipe_rd   = 5'($urandom_range(0, 31));
            pipe_data = {$urandom, $urandom};
            ll_valid  = $urandom_range(0, 1) == 1;
            ll_rd     = 5'($urandom_range(0, 31));
            ll_data   = {$urandom, $urandom};
            iss_v     = $urandom_range(0, 2) == 0;
            iss_rd    = 5'($urandom_range(0, 31));
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            settle();
            checks++; if (rf_we !== e_we) begin failures++; $display("FAIL rand_regwrite c=%0d got=%b exp=%b", c, rf_we, e_we); end
            checks++; if (rf_rd !== e_rd) begin failures++; $display("FAIL rand_rdaddr c=%0d got=%0d exp=%0d", c, rf_rd, e_rd); end
            checks++; if (rf_data !== e_data) begin failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, rf_data, e_data); end
            checks++; if (stall !== e_stall) begin failures++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, stall, e_stall); end
            checks++; if (ll_ready !== e_ready) begin failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, ll_ready, e_ready); end
            checks++; if ({rs1_busy, rs2_busy} !== {e_b1, e_b2}) begin failures++; $display("FAIL rand_busy c=%0d got=%b%b exp=%b%b", c, rs1_busy, rs2_busy, e_b1, e_b2); end
`ifdef RISCV_WBARB_FWD_EN
            checks++; if ({f1v, f2v} !== {e_f1v, e_f2v}) begin failures++; $display("FAIL rand_fwd c=%0d got=%b%b exp=%b%b", c, f1v, f2v, e_f1v, e_f2v); end
            if (e_f1v) begin
                checks++; if (f1d !== e_data) begin failures++; $display("FAIL rand_fwd1_data c=%0d got=%h exp=%h", c, f1d, e_data); end
            end
`endif
            advance();
        end
    endtask

    initial begin
        idle_inputs();
        model_clear();
        test_reset();
        test_idle_drain();
        test_starvation();
        test_full();
        test_x0();
`ifdef RISCV_WBARB_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
